// File: rtl/rv_test_monitor.sv
// Multi-hart test-completion monitor: arms on start, counts RUN cycles, and
// classifies each hart's result on ecall retire (pass/fail code) or by watchdog timeout.
module rv_test_monitor #(
  parameter int          NUM_HARTS      = 1,
  parameter int          XLEN           = 32,
  parameter int          TIMEOUT_CYCLES = 5000,
  parameter int unsigned PASS_VALUE     = 1,
  localparam int         CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_HARTS-1:0]      start,
  input  logic [NUM_HARTS-1:0]      ecall_valid,
  input  logic [NUM_HARTS*XLEN-1:0] gp_val,
  output logic [NUM_HARTS-1:0]      running,
  output logic [NUM_HARTS-1:0]      done,
  output logic [NUM_HARTS-1:0]      pass,
  output logic [NUM_HARTS-1:0]      timeout,
  output logic [NUM_HARTS-1:0]      done_pulse,
  output logic [NUM_HARTS*XLEN-1:0] fail_code,
  output logic [NUM_HARTS*CNT_W-1:0] cycles,
  output logic                      all_done,
  output logic                      all_pass
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_THR  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [XLEN-1:0]  PASS_GP  = XLEN'(PASS_VALUE);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_HARTS; gi++) begin : g_hart
      state_t            state_reg, state_next;
      logic [CNT_W-1:0]  cycles_reg, cycles_next;
      logic [XLEN-1:0]   fail_code_reg, fail_code_next;
      logic              pulse_reg, pulse_next;
      logic [XLEN-1:0]   gp;

      assign gp = gp_val[gi*XLEN +: XLEN];

      // Priority inside each state: start > ecall > timeout threshold.
      always_comb begin
        state_next     = state_reg;
        cycles_next    = cycles_reg;
        fail_code_next = fail_code_reg;
        pulse_next     = 1'b0;
        case (state_reg)
          S_IDLE: begin
            if (start[gi]) begin
              state_next     = S_RUN;
              cycles_next    = '0;
              fail_code_next = '0;
            end
          end
          S_RUN: begin
            if (start[gi]) begin
              cycles_next = '0;
            end else if (ecall_valid[gi]) begin
              // The ecall cycle itself is counted in the frozen total.
              cycles_next = (cycles_reg == CNT_MAX) ? CNT_MAX : cycles_reg + CNT_ONE;
              pulse_next  = 1'b1;
              if (gp == PASS_GP) begin
                state_next = S_PASS;
              end else begin
                state_next     = S_FAIL;
                fail_code_next = gp >> 1;
              end
            end else if (cycles_reg == CNT_THR) begin
              state_next  = S_TIMEOUT;
              cycles_next = CNT_MAX;
              pulse_next  = 1'b1;
            end else if (cycles_reg != CNT_MAX) begin
              cycles_next = cycles_reg + CNT_ONE;
            end
          end
          default: begin
            if (start[gi]) begin
              state_next     = S_RUN;
              cycles_next    = '0;
              fail_code_next = '0;
            end
          end
        endcase
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg     <= S_IDLE;
          cycles_reg    <= '0;
          fail_code_reg <= '0;
          pulse_reg     <= 1'b0;
        end else begin
          state_reg     <= state_next;
          cycles_reg    <= cycles_next;
          fail_code_reg <= fail_code_next;
          pulse_reg     <= pulse_next;
        end
      end

      assign running[gi]    = (state_reg == S_RUN);
      assign pass[gi]       = (state_reg == S_PASS);
      assign timeout[gi]    = (state_reg == S_TIMEOUT);
      assign done[gi]       = (state_reg == S_PASS) || (state_reg == S_FAIL) ||
                              (state_reg == S_TIMEOUT);
      assign done_pulse[gi] = pulse_reg;
      assign fail_code[gi*XLEN +: XLEN]   = fail_code_reg;
      assign cycles[gi*CNT_W +: CNT_W]    = cycles_reg;
    end
  endgenerate

  assign all_done = &done;
  assign all_pass = &pass;

endmodule

// File: tb/tb_rv_test_monitor.sv
// Directed bench for rv_test_monitor with two harts and the default 5000-cycle watchdog.
module tb_rv_test_monitor;
  localparam int NH    = 2;
  localparam int XL    = 32;
  localparam int TO    = 5000;
  localparam int CW    = $clog2(TO + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic [NH-1:0]   start;
  logic [NH-1:0]   ecall_valid;
  logic [NH*XL-1:0] gp_val;
  logic [NH-1:0]   running, done, pass, timeout, done_pulse;
  logic [NH*XL-1:0] fail_code;
  logic [NH*CW-1:0] cycles;
  logic            all_done, all_pass;

  int checks = 0;
  int errors = 0;

  rv_test_monitor #(
    .NUM_HARTS(NH), .XLEN(XL), .TIMEOUT_CYCLES(TO), .PASS_VALUE(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ecall_valid(ecall_valid), .gp_val(gp_val),
    .running(running), .done(done), .pass(pass), .timeout(timeout),
    .done_pulse(done_pulse), .fail_code(fail_code), .cycles(cycles),
    .all_done(all_done), .all_pass(all_pass)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [CW-1:0] cyc(input int h);
    return cycles[h*CW +: CW];
  endfunction

  function automatic logic [XL-1:0] fcode(input int h);
    return fail_code[h*XL +: XL];
  endfunction

  task automatic pulse_start(input int h);
    start[h] = 1'b1;
    tick(1);
    start[h] = 1'b0;
  endtask

  task automatic do_ecall(input int h, input logic [XL-1:0] gp);
    ecall_valid[h]     = 1'b1;
    gp_val[h*XL +: XL] = gp;
    tick(1);
    ecall_valid[h]     = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = '0; ecall_valid = '0; gp_val = '0;
    tick(3);
    check("rst running", running, 0);
    check("rst done", done, 0);
    check("rst pass", pass, 0);
    check("rst cycles", cycles, 0);
    check("rst all_done", all_done, 0);
    rst = 1'b0;
    tick(1);

    // 1: pass after 10 counted cycles plus the ecall cycle
    pulse_start(0);
    check("t1 running", running[0], 1);
    check("t1 cycles0", cyc(0), 0);
    tick(10);
    check("t1 cycles10", cyc(0), 10);
    do_ecall(0, 32'd1);
    check("t1 pass", pass[0], 1);
    check("t1 done_pulse", done_pulse[0], 1);
    check("t1 cycles", cyc(0), 11);
    check("t1 fail_code", fcode(0), 0);
    check("t1 running off", running[0], 0);
    tick(1);
    check("t1 pulse gone", done_pulse[0], 0);
    check("t1 pass sticky", pass[0], 1);

    // 2: fail with code gp>>1
    pulse_start(0);
    check("t2 pass cleared", pass[0], 0);
    do_ecall(0, 32'h0000_0007);
    check("t2 done", done[0], 1);
    check("t2 pass", pass[0], 0);
    check("t2 timeout", timeout[0], 0);
    check("t2 fail_code", fcode(0), 3);
    check("t2 cycles", cyc(0), 1);
    check("t2 done_pulse", done_pulse[0], 1);

    // 3: watchdog timeout, late ecall ignored
    pulse_start(0);
    check("t3 fail_code clr", fcode(0), 0);
    tick(TO - 1);
    check("t3 still running", running[0], 1);
    check("t3 cycles thr", cyc(0), TO - 1);
    check("t3 no timeout yet", timeout[0], 0);
    tick(1);
    check("t3 timeout", timeout[0], 1);
    check("t3 cycles sat", cyc(0), TO);
    check("t3 done_pulse", done_pulse[0], 1);
    check("t3 running off", running[0], 0);
    do_ecall(0, 32'd1);
    check("t3 late pass", pass[0], 0);
    check("t3 still timeout", timeout[0], 1);
    check("t3 pulse gone", done_pulse[0], 0);

    // 4: ecall on the threshold cycle wins over timeout
    pulse_start(0);
    tick(TO - 1);
    check("t4 cycles thr", cyc(0), TO - 1);
    do_ecall(0, 32'd1);
    check("t4 pass", pass[0], 1);
    check("t4 timeout", timeout[0], 0);
    check("t4 cycles", cyc(0), TO);

    // 5: hart1 times out while hart0 holds PASS, then restart hart1
    pulse_start(1);
    tick(TO);
    check("t5 h1 timeout", timeout[1], 1);
    check("t5 h0 pass", pass[0], 1);
    check("t5 all_done", all_done, 1);
    check("t5 all_pass", all_pass, 0);
    pulse_start(1);
    check("t5 h1 rerun", running[1], 1);
    check("t5 all_done drop", all_done, 0);
    tick(3);
    check("t5 h1 cycles3", cyc(1), 3);
    pulse_start(1);
    check("t5 restart cycles", cyc(1), 0);
    check("t5 restart no pulse", done_pulse[1], 0);
    check("t5 restart running", running[1], 1);
    gp_val[0 +: XL] = 32'h55;
    do_ecall(1, 32'd1);
    check("t5 h1 pass", pass[1], 1);
    check("t5 h1 cycles", cyc(1), 1);
    check("t5 h0 cycles kept", cyc(0), TO);
    check("t5 all_pass", all_pass, 1);

    // 6: reset mid-run discards everything; ecall without start ignored
    pulse_start(0);
    tick(5);
    check("t6 running", running[0], 1);
    rst = 1'b1;
    ecall_valid[0] = 1'b1;
    tick(1);
    rst = 1'b0;
    ecall_valid[0] = 1'b0;
    check("t6 running", running, 0);
    check("t6 done", done, 0);
    check("t6 pulse", done_pulse, 0);
    check("t6 cycles", cycles, 0);
    check("t6 fail_code", fail_code, 0);
    check("t6 all_pass", all_pass, 0);
    do_ecall(0, 32'd1);
    check("t6 idle ecall done", done[0], 0);
    check("t6 idle ecall run", running[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
